// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : switch_debouncer
// Description : Two-flop synchroniser plus per-switch tick-paced stability
//               counter for the board slide switches. Produces a registered,
//               glitch-free switch vector and optional one-cycle rise/fall
//               pulses per switch.
//               Optional feature macro: SW_EDGE_DETECT_EN
//                 defined   -> rise/fall pulse registers are built
//                 undefined -> SWITCH_RISE_O / SWITCH_FALL_O tied to 0
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debouncer #(
    parameter int NUM_SW       = 18,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 4
) (
    input  logic              CLOCK_50_I,
    input  logic              RESET_I,
    input  logic [NUM_SW-1:0] SWITCH_I,
    output logic [NUM_SW-1:0] SWITCH_DB_O,
    output logic [NUM_SW-1:0] SWITCH_RISE_O,
    output logic [NUM_SW-1:0] SWITCH_FALL_O
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W   = $clog2(STABLE_TICKS + 1);

    localparam logic [PRESC_W-1:0] c_presc_last = PRESC_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]   c_cnt_last   = CNT_W'(STABLE_TICKS - 1);
    localparam logic [CNT_W-1:0]   c_cnt_one    = CNT_W'(1);

    logic [NUM_SW-1:0]  r_meta;
    logic [NUM_SW-1:0]  r_sync;
    logic [NUM_SW-1:0]  r_db;
    logic [NUM_SW-1:0]  w_db_next;
    logic [PRESC_W-1:0] r_presc;
    logic               w_tick;
    logic [CNT_W-1:0]   r_cnt      [NUM_SW];
    logic [CNT_W-1:0]   w_cnt_next [NUM_SW];
`ifdef SW_EDGE_DETECT_EN
    logic [NUM_SW-1:0]  w_rise;
    logic [NUM_SW-1:0]  w_fall;
    logic [NUM_SW-1:0]  r_rise;
    logic [NUM_SW-1:0]  r_fall;
`endif

    // Two-flop synchroniser; the only consumer of the raw switch levels
    always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
        if (RESET_I) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= SWITCH_I;
            r_sync <= r_meta;
        end
    end

    // Shared sample prescaler; tick is the single cycle at the top count
    always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
        if (RESET_I) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    assign w_tick = (r_presc == c_presc_last);

    // Per-switch stability decision: any agreeing tick clears progress,
    // the STABLE_TICKS-th consecutive disagreeing tick accepts the new level
    always_comb begin
        w_db_next = r_db;
`ifdef SW_EDGE_DETECT_EN
        w_rise    = '0;
        w_fall    = '0;
`endif
        for (int i = 0; i < NUM_SW; i++) begin
            w_cnt_next[i] = r_cnt[i];
            if (w_tick) begin
                if (r_sync[i] == r_db[i]) begin
                    w_cnt_next[i] = '0;
                end else if (r_cnt[i] == c_cnt_last) begin
                    w_db_next[i]  = r_sync[i];
                    w_cnt_next[i] = '0;
`ifdef SW_EDGE_DETECT_EN
                    w_rise[i]     = r_sync[i];
                    w_fall[i]     = ~r_sync[i];
`endif
                end else begin
                    w_cnt_next[i] = r_cnt[i] + c_cnt_one;
                end
            end
        end
    end

    // Debounced level and stability counters
    always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
        if (RESET_I) begin
            r_db <= '0;
            for (int i = 0; i < NUM_SW; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_db <= w_db_next;
            for (int i = 0; i < NUM_SW; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
        end
    end

    assign SWITCH_DB_O = r_db;

`ifdef SW_EDGE_DETECT_EN
    // Edge pulses registered alongside the level so both appear together
    always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
        if (RESET_I) begin
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= w_rise;
            r_fall <= w_fall;
        end
    end

    assign SWITCH_RISE_O = r_rise;
    assign SWITCH_FALL_O = r_fall;
`else
    assign SWITCH_RISE_O = '0;
    assign SWITCH_FALL_O = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_debouncer
// Description : Directed self-checking bench for switch_debouncer with
//               TICK_DIV=4, STABLE_TICKS=3 (acceptance window 11..14 cycles).
//               Expected pulse values follow SW_EDGE_DETECT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_debouncer;

    localparam int NUM_SW  = 18;
    localparam int LAT_MIN = 11;
    localparam int LAT_MAX = 14;
`ifdef SW_EDGE_DETECT_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_SW-1:0] sw;
    logic [NUM_SW-1:0] db;
    logic [NUM_SW-1:0] rise;
    logic [NUM_SW-1:0] fall;

    int n_vec = 0;
    int n_err = 0;

    switch_debouncer #(
        .NUM_SW       (NUM_SW),
        .TICK_DIV     (4),
        .STABLE_TICKS (3)
    ) dut (
        .CLOCK_50_I    (clk),
        .RESET_I       (rst),
        .SWITCH_I      (sw),
        .SWITCH_DB_O   (db),
        .SWITCH_RISE_O (rise),
        .SWITCH_FALL_O (fall)
    );

    always #5 clk = ~clk;

    function automatic logic [NUM_SW-1:0] pulse_exp(input logic [NUM_SW-1:0] v);
        return EDGE_EN ? v : '0;
    endfunction

    // Apply reset for three cycles; returns just after release on a negedge
    task automatic apply_reset(input logic [NUM_SW-1:0] sw_val);
        @(negedge clk);
        rst = 1'b1;
        sw  = sw_val;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Count rising edges until db departs from 'old'; bounded at 40 cycles
    task automatic wait_change(input logic [NUM_SW-1:0] old, output int lat, output bit timeout);
        lat     = 0;
        timeout = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (db !== old) begin
                lat     = k;
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        sw  = '1;
        #1;
        n_vec++;
        if (db !== '0 || rise !== '0 || fall !== '0) begin
            n_err++;
            $display("FAIL reset_async: db=%h rise=%h fall=%h, required all 0", db, rise, fall);
        end
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (db !== '0 || rise !== '0 || fall !== '0) begin
            n_err++;
            $display("FAIL reset_held: db=%h rise=%h fall=%h, required all 0", db, rise, fall);
        end
        @(negedge clk);
        sw = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_rise();
        int lat;
        bit to;
        apply_reset('0);
        sw = 18'h00001;
        wait_change('0, lat, to);
        n_vec++;
        if (to || lat < LAT_MIN || lat > LAT_MAX) begin
            n_err++;
            $display("FAIL single_latency: got %0d cycles (timeout=%0d), required %0d..%0d", lat, to, LAT_MIN, LAT_MAX);
        end
        n_vec++;
        if (db !== 18'h00001 || rise !== pulse_exp(18'h00001) || fall !== '0) begin
            n_err++;
            $display("FAIL single_value: db=%h rise=%h fall=%h, required db=00001 rise=%h fall=0",
                     db, rise, fall, pulse_exp(18'h00001));
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (db !== 18'h00001 || rise !== '0 || fall !== '0) begin
            n_err++;
            $display("FAIL single_pulse_end: db=%h rise=%h fall=%h, required db=00001 rise=0 fall=0", db, rise, fall);
        end
    endtask

    task automatic test_glitch();
        int bad = 0;
        apply_reset('0);
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            sw = (k < 6) ? 18'h00002 : 18'h00000;
            @(posedge clk);
            #1;
            n_vec++;
            if (db !== '0 || rise !== '0 || fall !== '0) begin
                n_err++;
                bad++;
                if (bad <= 3)
                    $display("FAIL glitch cycle %0d: db=%h rise=%h fall=%h, required all 0", k, db, rise, fall);
            end
        end
    endtask

    task automatic test_multi_rise();
        int lat;
        bit to;
        apply_reset('0);
        sw = 18'h00007;
        wait_change('0, lat, to);
        n_vec++;
        if (to || lat < LAT_MIN || lat > LAT_MAX) begin
            n_err++;
            $display("FAIL multi_latency: got %0d cycles (timeout=%0d), required %0d..%0d", lat, to, LAT_MIN, LAT_MAX);
        end
        n_vec++;
        if (db !== 18'h00007 || rise !== pulse_exp(18'h00007) || fall !== '0) begin
            n_err++;
            $display("FAIL multi_value: db=%h rise=%h fall=%h, required db=00007 rise=%h fall=0",
                     db, rise, fall, pulse_exp(18'h00007));
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (db !== 18'h00007 || rise !== '0 || fall !== '0) begin
            n_err++;
            $display("FAIL multi_pulse_end: db=%h rise=%h fall=%h, required db=00007 rise=0 fall=0", db, rise, fall);
        end
    endtask

    // Continues from db=00007 left by test_multi_rise
    task automatic test_fall();
        int lat;
        bit to;
        @(negedge clk);
        sw = 18'h00003;
        wait_change(18'h00007, lat, to);
        n_vec++;
        if (to || lat < LAT_MIN || lat > LAT_MAX) begin
            n_err++;
            $display("FAIL fall_latency: got %0d cycles (timeout=%0d), required %0d..%0d", lat, to, LAT_MIN, LAT_MAX);
        end
        n_vec++;
        if (db !== 18'h00003 || fall !== pulse_exp(18'h00004) || rise !== '0) begin
            n_err++;
            $display("FAIL fall_value: db=%h rise=%h fall=%h, required db=00003 rise=0 fall=%h",
                     db, rise, fall, pulse_exp(18'h00004));
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (db !== 18'h00003 || rise !== '0 || fall !== '0) begin
            n_err++;
            $display("FAIL fall_pulse_end: db=%h rise=%h fall=%h, required db=00003 rise=0 fall=0", db, rise, fall);
        end
    endtask

    // Continues from db=00003: new level pending, then reset 8 cycles in
    task automatic test_reset_mid();
        int lat;
        bit to;
        @(negedge clk);
        sw = 18'h00013;
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (db !== '0 || rise !== '0 || fall !== '0) begin
            n_err++;
            $display("FAIL midreset_async: db=%h rise=%h fall=%h, required all 0", db, rise, fall);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_change('0, lat, to);
        n_vec++;
        if (to || lat < LAT_MIN || lat > LAT_MAX) begin
            n_err++;
            $display("FAIL midreset_latency: got %0d cycles (timeout=%0d), required %0d..%0d", lat, to, LAT_MIN, LAT_MAX);
        end
        n_vec++;
        if (db !== 18'h00013 || rise !== pulse_exp(18'h00013) || fall !== '0) begin
            n_err++;
            $display("FAIL midreset_value: db=%h rise=%h fall=%h, required db=00013 rise=%h fall=0",
                     db, rise, fall, pulse_exp(18'h00013));
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (db !== 18'h00013 || rise !== '0 || fall !== '0) begin
            n_err++;
            $display("FAIL midreset_pulse_end: db=%h rise=%h fall=%h, required db=00013 rise=0 fall=0", db, rise, fall);
        end
    endtask

    initial begin
        rst = 1'b1;
        sw  = '0;
        test_reset();
        test_single_rise();
        test_glitch();
        test_multi_rise();
        test_fall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
